// File: rtl/game_tick_pkg.sv
// Shared types, default parameters and the saturating divider-step helper for the
// dino-game tick generator.
package game_tick_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } game_state_e;

  localparam int unsigned DEF_CNT_W           = 28;
  localparam int unsigned DEF_START_DIV       = 700000;
  localparam int unsigned DEF_STEP            = 50000;
  localparam int unsigned DEF_MIN_DIV         = 350000;
  localparam int unsigned DEF_TICKS_PER_LEVEL = 10000;
  localparam int unsigned DEF_LVL_W           = 4;

  // Width used for divider arithmetic; callers zero-extend into it.
  localparam int unsigned DIV_CALC_W = 64;

  // Subtract step from div, but never go below min_div (threshold kept one bit wider).
  function automatic logic [DIV_CALC_W-1:0] div_step_sat(
    input logic [DIV_CALC_W-1:0] div,
    input logic [DIV_CALC_W-1:0] step,
    input logic [DIV_CALC_W-1:0] min_div
  );
    logic [DIV_CALC_W:0] thresh;
    thresh = {1'b0, min_div} + {1'b0, step};
    if ({1'b0, div} >= thresh) begin
      div_step_sat = div - step;
    end else begin
      div_step_sat = min_div;
    end
  endfunction

endpackage

// File: rtl/game_tick_gen_counter.sv
// Period counter for the game tick generator: counts 0..i_div and flags the wrap
// cycle; a synchronous clear overrides (and cancels) a wrap.
module tick_period_counter
  import game_tick_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_wrap
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = i_en & ~i_clr & (r_cnt >= i_div);
  assign o_wrap = w_wrap;

  // Counter register: clear, wrap to zero, or advance while enabled.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_wrap) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/game_tick_gen.sv
// Accelerating game-speed tick generator with pause/restart and level tracking.
// Optional GAME_TICK_TOGGLE_OUT_EN adds a square-wave o_clk_div output.
module game_tick_gen
  import game_tick_pkg::*;
#(
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter int unsigned START_DIV       = DEF_START_DIV,
  parameter int unsigned STEP            = DEF_STEP,
  parameter int unsigned MIN_DIV         = DEF_MIN_DIV,
  parameter int unsigned TICKS_PER_LEVEL = DEF_TICKS_PER_LEVEL,
  parameter int unsigned LVL_W           = DEF_LVL_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_restart,
  output logic             o_tick,
  output logic [LVL_W-1:0] o_level,
  output logic [CNT_W-1:0] o_divider,
  output logic             o_max_speed
`ifdef GAME_TICK_TOGGLE_OUT_EN
  ,
  output logic             o_clk_div
`endif
);

  localparam int TC_W = (TICKS_PER_LEVEL > 1) ? $clog2(TICKS_PER_LEVEL) : 1;
  localparam logic [TC_W-1:0]       TC_LAST   = TC_W'(TICKS_PER_LEVEL - 1);
  localparam logic [CNT_W-1:0]      START_V   = CNT_W'(START_DIV);
  localparam logic [CNT_W-1:0]      MIN_V     = CNT_W'(MIN_DIV);
  localparam logic [DIV_CALC_W-1:0] STEP_X    = DIV_CALC_W'(STEP);
  localparam logic [DIV_CALC_W-1:0] MIN_X     = DIV_CALC_W'(MIN_DIV);
  localparam logic                  RESET_MAX = (START_DIV == MIN_DIV) ? 1'b1 : 1'b0;

  game_state_e      r_state;
  logic             r_tick;
  logic [LVL_W-1:0] r_level;
  logic [CNT_W-1:0] r_divider;
  logic             r_max_speed;
  logic [TC_W-1:0]  r_tcnt;
  logic             w_clr;
  logic             w_cnt_en;
  logic             w_wrap;
  logic [CNT_W-1:0] w_div_next;

  assign w_clr      = i_rst | i_restart;
  // PAUSE counts on the resuming edge so an N-cycle pause costs exactly N cycles.
  assign w_cnt_en   = i_run & (r_state != ST_IDLE);
  assign w_div_next = CNT_W'(div_step_sat(DIV_CALC_W'(r_divider), STEP_X, MIN_X));

  tick_period_counter #(
    .CNT_W (CNT_W)
  ) u_period (
    .i_clk  (i_clk),
    .i_en   (w_cnt_en),
    .i_clr  (w_clr),
    .i_div  (r_divider),
    .o_wrap (w_wrap)
  );

  // Run-state FSM with tick, level, divider and speed-flag registers.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_restart) begin
      r_state     <= ST_IDLE;
      r_tick      <= 1'b0;
      r_level     <= {LVL_W{1'b0}};
      r_divider   <= START_V;
      r_max_speed <= RESET_MAX;
      r_tcnt      <= {TC_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE:  r_state <= i_run ? ST_RUN : ST_IDLE;
        ST_RUN:   r_state <= i_run ? ST_RUN : ST_PAUSE;
        ST_PAUSE: r_state <= i_run ? ST_RUN : ST_PAUSE;
        default:  r_state <= ST_IDLE;
      endcase
      r_tick <= w_wrap;
      if (w_wrap && (r_tcnt == TC_LAST)) begin
        r_tcnt      <= {TC_W{1'b0}};
        r_level     <= (r_level == {LVL_W{1'b1}}) ? r_level : r_level + LVL_W'(1);
        r_divider   <= w_div_next;
        r_max_speed <= (w_div_next == MIN_V);
      end else if (w_wrap) begin
        r_tcnt <= r_tcnt + TC_W'(1);
      end else begin
        r_tcnt <= r_tcnt;
      end
    end
  end

`ifdef GAME_TICK_TOGGLE_OUT_EN
  logic r_clk_div;

  // Legacy square wave: flips on every edge that raises the tick.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_restart) begin
      r_clk_div <= 1'b1;
    end else if (w_wrap) begin
      r_clk_div <= ~r_clk_div;
    end else begin
      r_clk_div <= r_clk_div;
    end
  end

  assign o_clk_div = r_clk_div;
`endif

  assign o_tick      = r_tick;
  assign o_level     = r_level;
  assign o_divider   = r_divider;
  assign o_max_speed = r_max_speed;

endmodule

// File: tb/tb_game_tick_gen.sv
// Directed self-checking bench for game_tick_gen (START_DIV=9, STEP=2, MIN_DIV=4,
// TICKS_PER_LEVEL=3); checks o_clk_div too when GAME_TICK_TOGGLE_OUT_EN is defined.
module tb_game_tick_gen;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned LVL_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             run;
  logic             restart;
  logic             tick;
  logic [LVL_W-1:0] level;
  logic [CNT_W-1:0] divider;
  logic             max_speed;
`ifdef GAME_TICK_TOGGLE_OUT_EN
  logic             clk_div;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  game_tick_gen #(
    .CNT_W           (CNT_W),
    .START_DIV       (9),
    .STEP            (2),
    .MIN_DIV         (4),
    .TICKS_PER_LEVEL (3),
    .LVL_W           (LVL_W)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_run       (run),
    .i_restart   (restart),
    .o_tick      (tick),
    .o_level     (level),
    .o_divider   (divider),
    .o_max_speed (max_speed)
`ifdef GAME_TICK_TOGGLE_OUT_EN
    ,
    .o_clk_div   (clk_div)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Count edges until tick is seen high; a missing tick shows up as a wrong gap.
  task automatic wait_tick(input string tag, input int exp_gap);
    int gap;
    gap = 0;
    do begin
      @(posedge clk);
      #1;
      gap++;
    end while ((tick !== 1'b1) && (gap < 400));
    chk(tag, gap, exp_gap);
  endtask

  task automatic chk_state(input string tag, input int exp_lvl, input int exp_div, input int exp_max);
    chk({tag, "_level"}, 32'(level), exp_lvl);
    chk({tag, "_divider"}, 32'(divider), exp_div);
    chk({tag, "_max_speed"}, 32'(max_speed), exp_max);
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;
    restart = 1'b0;
    cyc(2);
    chk("reset_tick", 32'(tick), 0);
    chk_state("reset", 0, 9, 0);
`ifdef GAME_TICK_TOGGLE_OUT_EN
    chk("reset_clk_div", 32'(clk_div), 1);
`endif
    rst = 1'b0;
    cyc(3);
    chk("idle_no_tick", 32'(tick), 0);

    // First tick arrives divider+1 edges after the edge that samples run.
    run = 1'b1;
    wait_tick("first_tick_gap", 11);
    chk_state("tick1", 0, 9, 0);
`ifdef GAME_TICK_TOGGLE_OUT_EN
    chk("clk_div_tick1", 32'(clk_div), 0);
`endif
    cyc(1);
    chk("tick_one_cycle", 32'(tick), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("pre_pause_no_tick", 32'(tick), 0);
    end

    // Counter now at 5: pause for 20 cycles, tick 2 lands 30 edges after tick 1.
    run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("pause_no_tick", 32'(tick), 0);
    end
    run = 1'b1;
    wait_tick("after_pause_gap", 5);
`ifdef GAME_TICK_TOGGLE_OUT_EN
    chk("clk_div_tick2", 32'(clk_div), 1);
`endif
    wait_tick("tick3_gap", 10);
    chk_state("tick3", 1, 7, 0);
    wait_tick("tick4_gap", 8);
    wait_tick("tick5_gap", 8);
    wait_tick("tick6_gap", 8);
    chk_state("tick6", 2, 5, 0);
    wait_tick("tick7_gap", 6);
    wait_tick("tick8_gap", 6);
    wait_tick("tick9_gap", 6);
    chk_state("tick9", 3, 4, 1);

    // Restart on the edge where the counter would wrap at level 3.
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("pre_restart_no_tick", 32'(tick), 0);
    end
    restart = 1'b1;
    run = 1'b0;
    cyc(1);
    chk("restart_cancels_tick", 32'(tick), 0);
    chk_state("restart", 0, 9, 0);
`ifdef GAME_TICK_TOGGLE_OUT_EN
    chk("restart_clk_div", 32'(clk_div), 1);
`endif
    restart = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cyc(1);
      chk("restart_idle_no_tick", 32'(tick), 0);
    end

    // Full acceleration run from restart through 12 ticks.
    run = 1'b1;
    wait_tick("r_tick1_gap", 11);
    wait_tick("r_tick2_gap", 10);
    wait_tick("r_tick3_gap", 10);
    chk_state("r_tick3", 1, 7, 0);
    wait_tick("r_tick4_gap", 8);
    wait_tick("r_tick5_gap", 8);
    wait_tick("r_tick6_gap", 8);
    chk_state("r_tick6", 2, 5, 0);
    wait_tick("r_tick7_gap", 6);
    wait_tick("r_tick8_gap", 6);
    wait_tick("r_tick9_gap", 6);
    chk_state("r_tick9", 3, 4, 1);
    wait_tick("r_tick10_gap", 5);
    wait_tick("r_tick11_gap", 5);
    wait_tick("r_tick12_gap", 5);
    chk_state("r_tick12", 4, 4, 1);
    wait_tick("r_tick13_gap", 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/game_tick_gen.md
# game_tick_gen

Parametrised game-speed tick generator for the dino game. Produces a single-cycle tick enable every `divider+1` system clocks and shortens that period by a fixed step after a set number of ticks, so the game accelerates level by level. It adds pause, restart, a level count and a saturation flag. It drives the game-logic update enable; all consumers stay on the single system clock.

## Interface
- `CNT_W`, 28: width of the period counter and divider.
- `START_DIV`, 700000: divider loaded at reset/restart.
- `STEP`, 50000: amount subtracted from the divider per level.
- `MIN_DIV`, 350000: floor for the divider; must satisfy MIN_DIV ≤ START_DIV.
- `TICKS_PER_LEVEL`, 10000: ticks per level; must be ≥ 1.
- `LVL_W`, 4: level counter width.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `run` in 1: 1 = count, 0 = pause (hold all state).
- `restart` in 1: synchronous game restart, same effect as `rst`.
- `tick` out 1: one-cycle pulse per game step.
- `level` out LVL_W: current level, saturating.
- `divider` out CNT_W: current period value.
- `max_speed` out 1: high when `divider == MIN_DIV`.

## Operation
- States: IDLE, RUN, PAUSE.
  - IDLE: entered on `rst`/`restart`. Goes to RUN when `run` = 1. The counter does not advance.
  - RUN: counter advances. Goes to PAUSE when `run` = 0.
  - PAUSE: counter and tick count are frozen. Goes to RUN when `run` = 1.
- Reset/restart values:
  - counter = 0, tick count = 0, `divider` = START_DIV, `level` = 0, `tick` = 0.
  - `max_speed` = (START_DIV == MIN_DIV).
  - State = IDLE.
- Counting in RUN with `run` = 1:
  - If counter < `divider`, counter increments.
  - Otherwise counter resets to 0 and `tick` is set to 1 for the next cycle.
- Level step, on a tick when tick count == TICKS_PER_LEVEL−1:
  - Tick count returns to 0.
  - `level` increments, holding at all-ones.
  - If `divider` ≥ MIN_DIV+STEP, `divider` drops by STEP; otherwise `divider` becomes MIN_DIV.
  - Compare in CNT_W+1 bits to avoid overflow.
  - On any other tick, tick count increments.
- Priority, highest first: `rst`, then `restart`, then `run`.
  - `restart` asserted together with a pending tick or level step cancels both.
- A divider change takes effect in the period that starts on the same edge, because the counter is already 0.

## Timing
- All outputs are registered.
- `tick` is high for exactly one cycle and never in consecutive cycles while `divider` ≥ 1.
- From IDLE, `run` sampled high at edge E0 gives the first `tick` high after edge E0+(`divider`+1).
- In steady RUN, ticks are `divider`+1 cycles apart.
- A pause of N cycles delays the next tick by exactly N cycles.
- `level`, `divider` and `max_speed` update on the same edge that raises the tick that completes a level.
- `restart` takes effect on the next edge; outputs show reset values one cycle later.

## Configuration
- `GAME_TICK_TOGGLE_OUT_EN` defined:
  - Adds output `clk_div` (1 bit), reset value 1.
  - `clk_div` inverts on each edge that raises `tick`, giving a square wave with half-period `divider`+1 for legacy display logic.
  - Reset and `restart` both return `clk_div` to 1.
- Macro not defined: the port and its register are absent. All other behaviour is identical.

## Structure
- Package `game_tick_pkg`:
  - State enum (IDLE/RUN/PAUSE).
  - Default parameter constants.
  - Divider-step helper function (saturating subtract).
- Sub-module `tick_period_counter`: counter plus compare, with `en`/`clr`/`div` inputs and a `wrap` output.
- The top level holds the FSM, the level/tick-count logic and the divider register.

## Test plan
Parameters for all scenarios: START_DIV=9, STEP=2, MIN_DIV=4, TICKS_PER_LEVEL=3.
- Reset, then `run`=1 held: first tick 10 cycles after `run` is sampled, then ticks every 10 cycles; `level`=0, `divider`=9.
- After the 3rd tick: `level`=1, `divider`=7, ticks now 8 cycles apart. After the 6th tick: `level`=2, `divider`=5.
- After the 9th tick: `divider`=4 (saturated, not 3), `max_speed`=1. After the 12th tick: `divider` stays 4, `level`=4.
- `run`=0 for 20 cycles at counter=5: no tick during the pause; the next tick arrives exactly 20 cycles later than without the pause; tick count is unchanged.
- `restart` pulsed at `level`=3 in the same cycle the counter wraps: no tick; next cycle `divider`=9, `level`=0, state IDLE; no ticks until `run` is sampled high.
- With `GAME_TICK_TOGGLE_OUT_EN`: `clk_div`=1 after reset and toggles on each tick (0 after the 1st, 1 after the 2nd); `restart` returns it to 1.
